// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Purpose:
//   Shares the single data-memory port between the CPU load/store path and an
//   auxiliary requester (debug/DMA). One access at a time, sequenced by a small
//   IDLE -> ACCESS -> DONE state machine. Memory busy is turned into a CPU
//   stall, and a watchdog aborts accesses whose memory stays busy too long.
//
//   Arbitration (default build): the CPU has fixed priority. A streak counter
//   limits the CPU to MAX_CPU_STREAK consecutive grants while aux_req is
//   pending, after which aux is served.
//   Optional feature macro DATA_MEM_ARB_RR_EN: when both ports request in
//   IDLE, the grant goes to the port that was not served last (CPU first after
//   reset). The streak counter is not built in that case.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cpu_addr/wdata/memread/memwrite CPU request (level, held while stalled)
//   cpu_sign_mask                   CPU size/sign mask
//   cpu_rdata                       CPU load data (registered)
//   cpu_stall                       CPU must hold its request (combinational)
//   aux_req/we/addr/wdata/sign_mask aux request, held until aux_ack
//   aux_ack, aux_rdata              one-cycle completion pulse + read data
//   mem_addr/wdata/memread/memwrite/sign_mask   to data memory (registered)
//   mem_rdata, mem_busy             from data memory
//   timeout_err                     sticky watchdog flag, cleared by reset only
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_CPU_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [3:0]        cpu_sign_mask,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic [3:0]        aux_sign_mask,
  output logic              aux_ack,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [3:0]        mem_sign_mask,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy,
  output logic              timeout_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic              owner_aux_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_memread_r;
  logic              mem_memwrite_r;
  logic [3:0]        mem_sign_mask_r;
  logic [DATA_W-1:0] cpu_rdata_r;
  logic [DATA_W-1:0] aux_rdata_r;
  logic              aux_ack_r;
  logic              timeout_err_r;
  logic [TO_W-1:0]   to_cnt_r;

  logic              cpu_req_s;
  logic              any_req_s;
  logic              grant_aux_s;
  logic              complete_s;
  logic              timeout_s;
  logic [DATA_W-1:0] capture_s;

  // A store wins when the CPU raises both strobes.
  assign cpu_req_s = cpu_memread | cpu_memwrite;
  assign any_req_s = cpu_req_s | aux_req;

`ifdef DATA_MEM_ARB_RR_EN
  logic last_aux_r;

  // Round-robin grant: on contention serve the port not served last.
  always_comb begin
    grant_aux_s = 1'b0;
    if (cpu_req_s && aux_req) begin
      grant_aux_s = ~last_aux_r;
    end else begin
      grant_aux_s = aux_req;
    end
  end

  // Remember the last owner; reset value makes the CPU win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_aux_r <= 1'b1;
    end else if (state_r == ST_IDLE && any_req_s) begin
      last_aux_r <= grant_aux_s;
    end
  end
`else
  localparam int STREAK_W = $clog2(MAX_CPU_STREAK + 1);
  logic [STREAK_W-1:0] streak_r;

  // Fixed CPU priority, except aux is forced in once the CPU streak saturates.
  always_comb begin
    grant_aux_s = 1'b0;
    if (aux_req && (!cpu_req_s || streak_r == STREAK_W'(MAX_CPU_STREAK))) begin
      grant_aux_s = 1'b1;
    end else begin
      grant_aux_s = 1'b0;
    end
  end

  // Count CPU grants made while aux is waiting; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_r <= {STREAK_W{1'b0}};
    end else if (!aux_req) begin
      streak_r <= {STREAK_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      if (grant_aux_s) begin
        streak_r <= {STREAK_W{1'b0}};
      end else if (streak_r != STREAK_W'(MAX_CPU_STREAK)) begin
        streak_r <= streak_r + STREAK_W'(1);
      end
    end
  end
`endif

  // Access termination: normal completion or watchdog abort on the last busy cycle.
  always_comb begin
    complete_s = 1'b0;
    timeout_s  = 1'b0;
    capture_s  = mem_rdata;
    if (state_r == ST_ACCESS) begin
      complete_s = ~mem_busy;
      timeout_s  = mem_busy && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
    end else begin
      complete_s = 1'b0;
      timeout_s  = 1'b0;
    end
    if (timeout_s) begin
      capture_s = {DATA_W{1'b1}};
    end else begin
      capture_s = mem_rdata;
    end
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          next_state_s = ST_ACCESS;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (complete_s || timeout_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_ACCESS;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Watchdog: counts busy cycles of the current access, restarts for each access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (state_r == ST_ACCESS && mem_busy && !timeout_s) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else if (state_r != ST_ACCESS) begin
      to_cnt_r <= {TO_W{1'b0}};
    end
  end

  // Latch the winner's request into the memory-side registers and capture results.
  // The memory outputs are loaded on entry to ACCESS and cleared on exit, so they
  // read as zero in IDLE and DONE and ignore request changes mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_aux_r     <= 1'b0;
      mem_addr_r      <= {ADDR_W{1'b0}};
      mem_wdata_r     <= {DATA_W{1'b0}};
      mem_memread_r   <= 1'b0;
      mem_memwrite_r  <= 1'b0;
      mem_sign_mask_r <= 4'h0;
      cpu_rdata_r     <= {DATA_W{1'b0}};
      aux_rdata_r     <= {DATA_W{1'b0}};
      aux_ack_r       <= 1'b0;
      timeout_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          aux_ack_r <= 1'b0;
          if (any_req_s) begin
            owner_aux_r     <= grant_aux_s;
            mem_addr_r      <= grant_aux_s ? aux_addr      : cpu_addr;
            mem_wdata_r     <= grant_aux_s ? aux_wdata     : cpu_wdata;
            mem_sign_mask_r <= grant_aux_s ? aux_sign_mask : cpu_sign_mask;
            mem_memwrite_r  <= grant_aux_s ? aux_we        : cpu_memwrite;
            mem_memread_r   <= grant_aux_s ? ~aux_we       : ~cpu_memwrite;
          end
        end
        ST_ACCESS: begin
          if (complete_s || timeout_s) begin
            mem_addr_r      <= {ADDR_W{1'b0}};
            mem_wdata_r     <= {DATA_W{1'b0}};
            mem_memread_r   <= 1'b0;
            mem_memwrite_r  <= 1'b0;
            mem_sign_mask_r <= 4'h0;
            aux_ack_r       <= owner_aux_r;
            if (owner_aux_r) begin
              aux_rdata_r <= capture_s;
            end else begin
              cpu_rdata_r <= capture_s;
            end
            if (timeout_s) begin
              timeout_err_r <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          aux_ack_r <= 1'b0;
        end
        default: begin
          mem_memread_r  <= 1'b0;
          mem_memwrite_r <= 1'b0;
          aux_ack_r      <= 1'b0;
        end
      endcase
    end
  end

  // The CPU is released only in the DONE cycle of its own access.
  assign cpu_stall = cpu_req_s && !(state_r == ST_DONE && !owner_aux_r);

  assign cpu_rdata     = cpu_rdata_r;
  assign aux_rdata     = aux_rdata_r;
  assign aux_ack       = aux_ack_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;
  assign mem_memread   = mem_memread_r;
  assign mem_memwrite  = mem_memwrite_r;
  assign mem_sign_mask = mem_sign_mask_r;
  assign timeout_err   = timeout_err_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Directed bench for data_mem_arbiter (MAX_CPU_STREAK=4, TIMEOUT_CYCLES=8).
// Expected read data is queued when a request is driven and popped when the
// DUT reports completion (cpu_stall low for the CPU, aux_ack for aux).
// Build with DATA_MEM_ARB_RR_EN defined to expect round-robin grant order.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_memread;
  logic        cpu_memwrite;
  logic [3:0]  cpu_sign_mask;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        aux_req;
  logic        aux_we;
  logic [31:0] aux_addr;
  logic [31:0] aux_wdata;
  logic [3:0]  aux_sign_mask;
  logic        aux_ack;
  logic [31:0] aux_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        timeout_err;

  int passed;
  int total;
  logic [31:0] cpu_q[$];
  logic [31:0] aux_q[$];

  data_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_CPU_STREAK(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_memread(cpu_memread),
    .cpu_memwrite(cpu_memwrite), .cpu_sign_mask(cpu_sign_mask),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_sign_mask(aux_sign_mask), .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_sign_mask(mem_sign_mask),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int     wr_cnt;
    int     rd_cnt;
    int     ack_cnt;
    int     ack_at;
    int     cpu_seen;
    int     k;
    bit     done;
    bit     strobe;
    bit     prev_strobe;
    bit     exp_aux[10];
    logic [31:0] exp_addr[10];

    passed = 0;
    total  = 0;
    rst_n = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_memread = 1'b0; cpu_memwrite = 1'b0;
    cpu_sign_mask = 4'h0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = 32'h0; aux_wdata = 32'h0;
    aux_sign_mask = 4'h0;
    mem_rdata = 32'h0; mem_busy = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_mem_memread", mem_memread, 64'd0);
    chk("rst_mem_memwrite", mem_memwrite, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_cpu_rdata", cpu_rdata, 64'd0);
    chk("rst_aux_rdata", aux_rdata, 64'd0);
    chk("rst_aux_ack", aux_ack, 64'd0);
    chk("rst_timeout_err", timeout_err, 64'd0);
    chk("rst_cpu_stall", cpu_stall, 64'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- 1: CPU load, zero-wait ----------------
    cpu_addr = 32'h0000_1000; cpu_memread = 1'b1; cpu_sign_mask = 4'h3;
    mem_rdata = 32'hDEAD_BEEF; mem_busy = 1'b0;
    cpu_q.push_back(32'hDEAD_BEEF);
    #1;
    chk("t1_stall_idle", cpu_stall, 64'd1);
    chk("t1_memread_idle", mem_memread, 64'd0);
    tick();
    chk("t1_stall_access", cpu_stall, 64'd1);
    chk("t1_memread_access", mem_memread, 64'd1);
    chk("t1_addr_access", mem_addr, 64'h1000);
    chk("t1_mask_access", mem_sign_mask, 64'h3);
    tick();
    chk("t1_stall_done", cpu_stall, 64'd0);
    chk("t1_memread_done", mem_memread, 64'd0);
    chk("t1_cpu_rdata", cpu_rdata, cpu_q.pop_front());
    cpu_memread = 1'b0;
    tick();
    chk("t1_memread_after", mem_memread, 64'd0);

    // ---------------- 2: aux write, memory busy for 3 cycles ----------------
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h0000_2000;
    aux_wdata = 32'h1234_5678; aux_sign_mask = 4'hF; mem_busy = 1'b1;
    wr_cnt = 0; ack_cnt = 0; ack_at = -1; cpu_seen = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (mem_memwrite) begin
        wr_cnt++;
        if (wr_cnt == 1) begin
          chk("t2_addr", mem_addr, 64'h2000);
          chk("t2_wdata", mem_wdata, 64'h1234_5678);
          chk("t2_memread_low", mem_memread, 64'd0);
        end
        mem_busy = (wr_cnt <= 3);
      end else begin
        mem_busy = 1'b0;
      end
      if (aux_ack) begin
        ack_cnt++;
        ack_at = c;
        aux_req = 1'b0;
      end
      if (cpu_stall) cpu_seen++;
    end
    chk("t2_write_cycles", wr_cnt, 64'd4);
    chk("t2_ack_count", ack_cnt, 64'd1);
    chk("t2_ack_cycle", ack_at, 64'd5);
    chk("t2_no_cpu_stall", cpu_seen, 64'd0);
    chk("t2_no_timeout", timeout_err, 64'd0);

    // ---------------- 3: CPU streak vs held aux_req ----------------
    for (int i = 0; i < 10; i++) begin
`ifdef DATA_MEM_ARB_RR_EN
      exp_aux[i] = (i % 2) == 1;
`else
      exp_aux[i] = (i % 5) == 4;
`endif
      exp_addr[i] = exp_aux[i] ? 32'h0000_4000 : 32'h0000_3000;
      if (exp_aux[i]) aux_q.push_back(32'hA000_0000 + 32'(i));
      else            cpu_q.push_back(32'hA000_0000 + 32'(i));
    end
    cpu_addr = 32'h0000_3000; cpu_memread = 1'b1; cpu_memwrite = 1'b0;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h0000_4000;
    mem_busy = 1'b0;
    k = 0; prev_strobe = 1'b0;
    for (int c = 0; c < 80 && !(k == 10 && cpu_q.size() == 0 && aux_q.size() == 0); c++) begin
      tick();
      strobe = mem_memread | mem_memwrite;
      if (strobe && !prev_strobe) begin
        if (k < 10) begin
          chk($sformatf("t3_grant%0d_addr", k), mem_addr, exp_addr[k]);
          mem_rdata = 32'hA000_0000 + 32'(k);
        end
        k++;
        if (k == 10) cpu_memread = 1'b0;
      end
      prev_strobe = strobe;
      if (cpu_memread && !cpu_stall) begin
        if (cpu_q.size() > 0) chk("t3_cpu_rdata", cpu_rdata, cpu_q.pop_front());
        else chk("t3_cpu_extra_done", cpu_q.size(), 64'd1);
      end
      if (aux_ack) begin
        if (aux_q.size() > 0) chk("t3_aux_rdata", aux_rdata, aux_q.pop_front());
        else chk("t3_aux_extra_ack", aux_q.size(), 64'd1);
        if (aux_q.size() == 0) aux_req = 1'b0;
      end
    end
    chk("t3_grant_count", k, 64'd10);
    chk("t3_queues_drained", cpu_q.size() + aux_q.size(), 64'd0);
    aux_req = 1'b0; cpu_memread = 1'b0;
    tick();
    tick();

    // ---------------- 4: watchdog on stuck mem_busy ----------------
    cpu_addr = 32'h0000_5000; cpu_memread = 1'b1; mem_busy = 1'b1;
    cpu_q.push_back(32'hFFFF_FFFF);
    rd_cnt = 0; done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      tick();
      if (mem_memread) rd_cnt++;
      if (!cpu_stall) begin
        done = 1'b1;
        chk("t4_cpu_rdata", cpu_rdata, cpu_q.pop_front());
        chk("t4_timeout_err_set", timeout_err, 64'd1);
        cpu_memread = 1'b0;
        mem_busy = 1'b0;
      end
    end
    chk("t4_completed", done, 64'd1);
    chk("t4_access_cycles", rd_cnt, 64'd8);
    tick();
    // Good access afterwards: both strobes high must become a write.
    cpu_addr = 32'h0000_6000; cpu_wdata = 32'hAAAA_5555;
    cpu_memread = 1'b1; cpu_memwrite = 1'b1;
    tick();
    chk("t4b_memwrite", mem_memwrite, 64'd1);
    chk("t4b_memread", mem_memread, 64'd0);
    chk("t4b_wdata", mem_wdata, 64'hAAAA_5555);
    tick();
    chk("t4b_stall_done", cpu_stall, 64'd0);
    chk("t4b_timeout_sticky", timeout_err, 64'd1);
    cpu_memread = 1'b0; cpu_memwrite = 1'b0;
    tick();

    // ---------------- 5: reset in the middle of an aux access ----------------
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h0000_7000; mem_busy = 1'b1;
    tick();
    chk("t5_memread_access", mem_memread, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_memread", mem_memread, 64'd0);
    chk("t5_rst_addr", mem_addr, 64'd0);
    chk("t5_rst_aux_ack", aux_ack, 64'd0);
    chk("t5_rst_timeout_err", timeout_err, 64'd0);
    chk("t5_rst_cpu_rdata", cpu_rdata, 64'd0);
    aux_req = 1'b0; mem_busy = 1'b0;
    ack_cnt = 0;
    tick();
    if (aux_ack) ack_cnt++;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (aux_ack) ack_cnt++;
    end
    chk("t5_no_ack_after_reset", ack_cnt, 64'd0);
    chk("t5_idle_memread", mem_memread, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
